memory_island_bank_arbiter: RTL and testbench
=============================================

# memory_island_bank_arbiter

Parametrised successor to the fixed-priority wide/narrow arbitration stage of the memory island. One instance serves a group of `NumPorts` narrow SRAM banks that together form one wide bank. The block arbitrates per cycle between one wide request, which needs all banks of the group atomically, and up to `NumPorts` independent narrow requests. It supports three selectable priority modes, a starvation bound, and tag-tracked response return for any fixed bank latency ≥ 1.

## Interface
- `NumPorts`, 4: narrow banks per group (power of 2, ≥ 2).
- `AddrWidth`, 16: bank-local word address width.
- `DataWidth`, 32: narrow bank data width; wide data is `NumPorts*DataWidth`.
- `BankLatency`, 1: cycles from bank request to read data (≥ 1).
- `Mode`, `ARB_NARROW_FIRST`: one of `ARB_NARROW_FIRST`, `ARB_WIDE_FIRST`, `ARB_ROUND_ROBIN`.
- `MaxStall`, 8: contended cycles before the losing class is forced; 0 disables forcing.

Ports:
- `clk_i`  in  1  clock. One clock; reset is synchronous and active-low.
- `rst_ni`  in  1  synchronous active-low reset.
- `narrow_req_valid_i`  in  `NumPorts`  per-bank narrow request valid.
- `narrow_req_ready_o`  out  `NumPorts`  per-bank narrow grant.
- `narrow_req_addr_i`  in  `NumPorts*AddrWidth`  narrow addresses.
- `narrow_req_we_i`  in  `NumPorts`  write enables.
- `narrow_req_wdata_i`  in  `NumPorts*DataWidth`  write data.
- `narrow_req_strb_i`  in  `NumPorts*DataWidth/8`  byte strobes.
- `narrow_rsp_valid_o`  out  `NumPorts`  response valid.
- `narrow_rsp_rdata_o`  out  `NumPorts*DataWidth`  read data.
- `wide_req_valid_i` / `wide_req_ready_o`  in / out  1  wide handshake.
- `wide_req_addr_i`  in  `AddrWidth`  wide address, the same row in every bank.
- `wide_req_we_i`  in  1  wide write enable.
- `wide_req_wdata_i` / `wide_req_strb_i`  in  `NumPorts*DataWidth` / `NumPorts*DataWidth/8`  wide write data and strobes; slice i goes to bank i.
- `wide_rsp_valid_o` / `wide_rsp_rdata_o`  out  1 / `NumPorts*DataWidth`  wide response.
- `bank_req_o`, `bank_we_o`  out  `NumPorts` each  bank request and write enable.
- `bank_addr_o`, `bank_wdata_o`, `bank_be_o`  out  per-bank vectors  bank request fields.
- `bank_rdata_i`  in  `NumPorts*DataWidth`  bank read data.
- `wide_starved_o`, `narrow_starved_o`  out  1 each  high when the respective stall counter equals `MaxStall`.

## Operation
- A valid/ready transfer occurs when valid and ready are both high. Ready is combinational from the valids and the arbiter state. Requesters hold their request until ready.
- Contention exists when `wide_req_valid_i` is high and any narrow valid is high.
- With no contention, every valid requester is granted.
- Wide grant: all `bank_req_o` bits high, driven from the wide slices; all narrow ready signals low.
- Narrow grant: `bank_req_o[i] = narrow_req_valid_i[i]`; wide ready low.
- Priority under contention:
  - `ARB_NARROW_FIRST`: narrow wins unless `wide_stall_q == MaxStall`, in which case wide wins.
  - `ARB_WIDE_FIRST`: wide wins unless `narrow_stall_q == MaxStall`, in which case narrow wins.
  - `ARB_ROUND_ROBIN`: the `rr_token_q` owner wins. The token flips after every contended grant. `MaxStall` is ignored.
- Stall counters:
  - A counter increments, saturating at `MaxStall`, in each contended cycle its class loses.
  - It clears on a grant to its class or when that class's valid is low.
  - Width is `$clog2(MaxStall+1)`, minimum 1.
- Responses: every grant, read or write, produces a response. Writes return `rdata` equal to `bank_rdata_i`, which is a don't-care.
  - A tag `{valid, is_wide, narrow_mask}` enters a `BankLatency`-deep shift register.
  - At the output, a wide tag drives `wide_rsp_valid_o` with `bank_rdata_i` concatenated.
  - A narrow tag drives `narrow_rsp_valid_o = narrow_mask`, with per-bank data.
  - There is no response backpressure.

## Timing
- Request to bank: 0 cycles (combinational grant).
- Grant in cycle t gives a response valid in cycle t+`BankLatency`. Throughput is one grant set per cycle.
- Reset values: stall counters 0, `rr_token_q` = narrow, all tag valids 0. All response valids and starved flags are therefore 0.
- Reset mid-operation clears in-flight tags. Responses for requests granted before reset are dropped.
- A `MaxStall` force and a token flip never occur together, because they belong to exclusive modes.
- A counter already at `MaxStall` stays saturated while it keeps losing. That cannot happen, since the force wins that cycle.

## Structure
- `memory_island_pkg` gains the `arb_mode_e` enum and the `bank_rsp_tag_t` struct, parametrised via localparam widths.
- Sub-module `bank_rsp_tag_pipe`: a `BankLatency`-deep shift register of tags with synchronous reset.
- Elaboration assertions: `BankLatency >= 1`; `NumPorts` is a power of 2; `DataWidth % 8 == 0`.

## Test plan
- `ARB_NARROW_FIRST`, `MaxStall`=3, narrow bank 0 valid every cycle and wide valid from cycle 0:
  - wide granted at cycle 3;
  - `wide_starved_o` high at cycle 3;
  - wide response at cycle 3+`BankLatency`.
- `ARB_WIDE_FIRST`, `MaxStall`=2, continuous wide writes plus a narrow read on bank 2: narrow granted every 3rd cycle and its rdata returned only on `narrow_rsp_valid_o[2]`.
- `ARB_ROUND_ROBIN`, continuous contention: grants alternate narrow, wide, narrow, wide, starting narrow after reset.
- `BankLatency`=3: write 0xA5A5_0000+i to each bank via a wide request, then wide-read the same address. Wide rdata matches, and the response arrives exactly 3 cycles after the grant.
- Narrow-only traffic on banks 0 and 3: both granted the same cycle; `narrow_rsp_valid_o`=4'b1001.
- Assert `rst_ni` low for one cycle with 2 requests in flight (`BankLatency`=2): no responses appear afterwards, and counters and token are back at their reset values.

Source files
------------

// File: rtl/memory_island_bank_arbiter_pkg.sv
// Shared types for the memory-island wide/narrow bank arbiter: priority modes,
// the in-flight response tag and the stall counter width helper.
package memory_island_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_NARROW_FIRST = 2'd0,
    ARB_WIDE_FIRST   = 2'd1,
    ARB_ROUND_ROBIN  = 2'd2
  } arb_mode_e;

  // Upper bound on banks per group; the tag mask is sized for it and the
  // arbiter uses the low NumPorts bits.
  localparam int unsigned MaxNumPorts = 16;

  typedef struct packed {
    logic                   valid;
    logic                   is_wide;
    logic [MaxNumPorts-1:0] narrow_mask;
  } bank_rsp_tag_t;

  function automatic int unsigned stall_width(input int unsigned max_stall);
    return (max_stall == 0) ? 1 : $clog2(max_stall + 1);
  endfunction

endpackage

// File: rtl/memory_island_bank_arbiter_if.sv
// Request, response and bank-side bundle of one arbiter group. The slave
// modport is the arbiter; the master modport is the requester/SRAM side.
interface memory_island_bank_arbiter_if #(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned StrbWidth = NumPorts * DataWidth / 8;

  logic [NumPorts-1:0]           narrow_req_valid_i;
  logic [NumPorts-1:0]           narrow_req_ready_o;
  logic [NumPorts*AddrWidth-1:0] narrow_req_addr_i;
  logic [NumPorts-1:0]           narrow_req_we_i;
  logic [NumPorts*DataWidth-1:0] narrow_req_wdata_i;
  logic [StrbWidth-1:0]          narrow_req_strb_i;
  logic [NumPorts-1:0]           narrow_rsp_valid_o;
  logic [NumPorts*DataWidth-1:0] narrow_rsp_rdata_o;
  logic                          wide_req_valid_i;
  logic                          wide_req_ready_o;
  logic [AddrWidth-1:0]          wide_req_addr_i;
  logic                          wide_req_we_i;
  logic [NumPorts*DataWidth-1:0] wide_req_wdata_i;
  logic [StrbWidth-1:0]          wide_req_strb_i;
  logic                          wide_rsp_valid_o;
  logic [NumPorts*DataWidth-1:0] wide_rsp_rdata_o;
  logic [NumPorts-1:0]           bank_req_o;
  logic [NumPorts-1:0]           bank_we_o;
  logic [NumPorts*AddrWidth-1:0] bank_addr_o;
  logic [NumPorts*DataWidth-1:0] bank_wdata_o;
  logic [StrbWidth-1:0]          bank_be_o;
  logic [NumPorts*DataWidth-1:0] bank_rdata_i;
  logic                          wide_starved_o;
  logic                          narrow_starved_o;

  modport slave (
    input  narrow_req_valid_i, narrow_req_addr_i, narrow_req_we_i,
           narrow_req_wdata_i, narrow_req_strb_i, wide_req_valid_i,
           wide_req_addr_i, wide_req_we_i, wide_req_wdata_i, wide_req_strb_i,
           bank_rdata_i,
    output narrow_req_ready_o, narrow_rsp_valid_o, narrow_rsp_rdata_o,
           wide_req_ready_o, wide_rsp_valid_o, wide_rsp_rdata_o,
           bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
           wide_starved_o, narrow_starved_o
  );

  modport master (
    output narrow_req_valid_i, narrow_req_addr_i, narrow_req_we_i,
           narrow_req_wdata_i, narrow_req_strb_i, wide_req_valid_i,
           wide_req_addr_i, wide_req_we_i, wide_req_wdata_i, wide_req_strb_i,
           bank_rdata_i,
    input  narrow_req_ready_o, narrow_rsp_valid_o, narrow_rsp_rdata_o,
           wide_req_ready_o, wide_rsp_valid_o, wide_rsp_rdata_o,
           bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
           wide_starved_o, narrow_starved_o
  );

endinterface

// File: rtl/memory_island_bank_arbiter_tag_pipe.sv
// Delay line that carries each grant's response tag alongside the fixed
// SRAM read latency, so responses are steered to the requester class that issued them.
module bank_rsp_tag_pipe
  import memory_island_bank_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  bank_rsp_tag_t i_tag,
  output bank_rsp_tag_t o_tag
);

  bank_rsp_tag_t r_tags [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) r_tags[i] <= '0;
    end else begin
      r_tags[0] <= i_tag;
      for (int unsigned i = 1; i < Depth; i++) r_tags[i] <= r_tags[i-1];
    end
  end

  assign o_tag = r_tags[Depth-1];

endmodule

// File: rtl/memory_island_bank_arbiter.sv
// Per-cycle arbitration of one atomic wide request against NumPorts narrow
// requests over a bank group, with starvation forcing and tagged responses.
module memory_island_bank_arbiter
  import memory_island_bank_arbiter_pkg::*;
#(
  parameter int unsigned NumPorts    = 4,
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned BankLatency = 1,
  parameter arb_mode_e   Mode        = ARB_NARROW_FIRST,
  parameter int unsigned MaxStall    = 8
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  memory_island_bank_arbiter_if.slave bus
);

  localparam int unsigned            StallWidth = stall_width(MaxStall);
  localparam logic [StallWidth-1:0]  StallMax   = StallWidth'(MaxStall);
  localparam bit                     ForceEn    = (MaxStall != 0);

  if (BankLatency < 1) begin : g_err_latency
    $error("BankLatency must be at least 1");
  end
  if ((NumPorts < 2) || ((NumPorts & (NumPorts - 1)) != 0)) begin : g_err_ports
    $error("NumPorts must be a power of 2 and at least 2");
  end
  if (NumPorts > MaxNumPorts) begin : g_err_ports_max
    $error("NumPorts exceeds the tag mask width");
  end
  if ((DataWidth % 8) != 0) begin : g_err_data
    $error("DataWidth must be a multiple of 8");
  end

  logic [StallWidth-1:0] r_wide_stall;
  logic [StallWidth-1:0] r_narrow_stall;
  logic                  r_rr_token;  // 0: narrow owns the token, 1: wide
  logic                  w_narrow_any;
  logic                  w_contention;
  logic                  w_wide_prio;
  logic                  w_wide_gnt;
  logic                  w_narrow_gnt;
  logic [NumPorts-1:0]   w_narrow_ready;
  bank_rsp_tag_t         w_tag_in;
  bank_rsp_tag_t         w_tag_out;
  logic                  w_unused_tag_mask;

  assign w_narrow_any = |bus.narrow_req_valid_i;
  assign w_contention = bus.wide_req_valid_i & w_narrow_any;

  always_comb begin
    w_wide_prio = 1'b0;
    case (Mode)
      ARB_NARROW_FIRST: w_wide_prio = ForceEn && (r_wide_stall == StallMax);
      ARB_WIDE_FIRST:   w_wide_prio = !(ForceEn && (r_narrow_stall == StallMax));
      ARB_ROUND_ROBIN:  w_wide_prio = r_rr_token;
      default:          w_wide_prio = 1'b0;
    endcase
  end

  assign w_wide_gnt     = bus.wide_req_valid_i & (~w_narrow_any | w_wide_prio);
  assign w_narrow_gnt   = w_narrow_any & ~w_wide_gnt;
  assign w_narrow_ready = w_narrow_gnt ? bus.narrow_req_valid_i : '0;

  assign bus.wide_req_ready_o   = w_wide_gnt;
  assign bus.narrow_req_ready_o = w_narrow_ready;

  assign bus.bank_req_o   = w_wide_gnt ? '1 : w_narrow_ready;
  assign bus.bank_we_o    = w_wide_gnt ? {NumPorts{bus.wide_req_we_i}} : bus.narrow_req_we_i;
  assign bus.bank_addr_o  = w_wide_gnt ? {NumPorts{bus.wide_req_addr_i}} : bus.narrow_req_addr_i;
  assign bus.bank_wdata_o = w_wide_gnt ? bus.wide_req_wdata_i : bus.narrow_req_wdata_i;
  assign bus.bank_be_o    = w_wide_gnt ? bus.wide_req_strb_i : bus.narrow_req_strb_i;

  // A class's counter only advances in cycles it contends and loses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wide_stall   <= '0;
      r_narrow_stall <= '0;
      r_rr_token     <= 1'b0;
    end else begin
      if (!bus.wide_req_valid_i || w_wide_gnt) begin
        r_wide_stall <= '0;
      end else if (w_contention && (r_wide_stall != StallMax)) begin
        r_wide_stall <= r_wide_stall + 1'b1;
      end
      if (!w_narrow_any || w_narrow_gnt) begin
        r_narrow_stall <= '0;
      end else if (w_contention && (r_narrow_stall != StallMax)) begin
        r_narrow_stall <= r_narrow_stall + 1'b1;
      end
      if (w_contention) r_rr_token <= ~r_rr_token;
    end
  end

  assign bus.wide_starved_o   = ForceEn && (r_wide_stall == StallMax);
  assign bus.narrow_starved_o = ForceEn && (r_narrow_stall == StallMax);

  always_comb begin
    w_tag_in                           = '0;
    w_tag_in.valid                     = w_wide_gnt | w_narrow_gnt;
    w_tag_in.is_wide                   = w_wide_gnt;
    w_tag_in.narrow_mask[NumPorts-1:0] = w_narrow_ready;
  end

  bank_rsp_tag_pipe #(
    .Depth (BankLatency)
  ) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  // Bits above NumPorts are always zero in the tag.
  assign w_unused_tag_mask = ^w_tag_out.narrow_mask;

  assign bus.wide_rsp_valid_o   = w_tag_out.valid & w_tag_out.is_wide;
  assign bus.wide_rsp_rdata_o   = bus.bank_rdata_i;
  assign bus.narrow_rsp_valid_o = (w_tag_out.valid & ~w_tag_out.is_wide)
                                ? w_tag_out.narrow_mask[NumPorts-1:0] : '0;
  assign bus.narrow_rsp_rdata_o = bus.bank_rdata_i;

endmodule

// File: tb/tb_memory_island_bank_arbiter.sv
// Directed bench: four arbiter instances (narrow-first, wide-first,
// round-robin, latency-3 with an SRAM model) driven one scenario at a time.
module tb_memory_island_bank_arbiter;
  import memory_island_bank_arbiter_pkg::*;

  localparam logic [127:0] RD = 128'h4444_0004_3333_0003_2222_0002_1111_0001;
  localparam logic [127:0] WIDE_PAT = 128'hA5A5_0003_A5A5_0002_A5A5_0001_A5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memory_island_bank_arbiter_if #(.NumPorts(4), .AddrWidth(16), .DataWidth(32)) a_if ();
  memory_island_bank_arbiter_if #(.NumPorts(4), .AddrWidth(16), .DataWidth(32)) b_if ();
  memory_island_bank_arbiter_if #(.NumPorts(4), .AddrWidth(16), .DataWidth(32)) c_if ();
  memory_island_bank_arbiter_if #(.NumPorts(4), .AddrWidth(16), .DataWidth(32)) d_if ();

  memory_island_bank_arbiter #(.NumPorts(4), .AddrWidth(16), .DataWidth(32), .BankLatency(1),
    .Mode(ARB_NARROW_FIRST), .MaxStall(3)) u_a (.clk_i(clk), .rst_ni(rst_n), .bus(a_if.slave));
  memory_island_bank_arbiter #(.NumPorts(4), .AddrWidth(16), .DataWidth(32), .BankLatency(1),
    .Mode(ARB_WIDE_FIRST), .MaxStall(2)) u_b (.clk_i(clk), .rst_ni(rst_n), .bus(b_if.slave));
  memory_island_bank_arbiter #(.NumPorts(4), .AddrWidth(16), .DataWidth(32), .BankLatency(2),
    .Mode(ARB_ROUND_ROBIN), .MaxStall(8)) u_c (.clk_i(clk), .rst_ni(rst_n), .bus(c_if.slave));
  memory_island_bank_arbiter #(.NumPorts(4), .AddrWidth(16), .DataWidth(32), .BankLatency(3),
    .Mode(ARB_NARROW_FIRST), .MaxStall(8)) u_d (.clk_i(clk), .rst_ni(rst_n), .bus(d_if.slave));

  assign a_if.bank_rdata_i = RD;
  assign b_if.bank_rdata_i = RD;
  assign c_if.bank_rdata_i = RD;

  // Three-cycle SRAM model behind instance d
  logic [31:0] d_mem [4][16];
  logic [31:0] d_s1 [4];
  logic [31:0] d_s2 [4];
  logic [31:0] d_s3 [4];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (d_if.bank_req_o[b]) begin
        if (d_if.bank_we_o[b]) d_mem[b][d_if.bank_addr_o[b*16 +: 4]] <= d_if.bank_wdata_o[b*32 +: 32];
        d_s1[b] <= d_mem[b][d_if.bank_addr_o[b*16 +: 4]];
      end
      d_s2[b] <= d_s1[b];
      d_s3[b] <= d_s2[b];
    end
  end

  assign d_if.bank_rdata_i = {d_s3[3], d_s3[2], d_s3[1], d_s3[0]};

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_all();
    a_if.narrow_req_valid_i = '0; a_if.wide_req_valid_i = 1'b0;
    b_if.narrow_req_valid_i = '0; b_if.wide_req_valid_i = 1'b0;
    c_if.narrow_req_valid_i = '0; c_if.wide_req_valid_i = 1'b0;
    d_if.narrow_req_valid_i = '0; d_if.wide_req_valid_i = 1'b0;
  endtask

  task automatic clear_fields();
    a_if.narrow_req_addr_i = '0; a_if.narrow_req_we_i = '0; a_if.narrow_req_wdata_i = '0;
    a_if.narrow_req_strb_i = '0; a_if.wide_req_addr_i = '0; a_if.wide_req_we_i = 1'b0;
    a_if.wide_req_wdata_i = '0; a_if.wide_req_strb_i = '0;
    b_if.narrow_req_addr_i = '0; b_if.narrow_req_we_i = '0; b_if.narrow_req_wdata_i = '0;
    b_if.narrow_req_strb_i = '0; b_if.wide_req_addr_i = '0; b_if.wide_req_we_i = 1'b0;
    b_if.wide_req_wdata_i = '0; b_if.wide_req_strb_i = '0;
    c_if.narrow_req_addr_i = '0; c_if.narrow_req_we_i = '0; c_if.narrow_req_wdata_i = '0;
    c_if.narrow_req_strb_i = '0; c_if.wide_req_addr_i = '0; c_if.wide_req_we_i = 1'b0;
    c_if.wide_req_wdata_i = '0; c_if.wide_req_strb_i = '0;
    d_if.narrow_req_addr_i = '0; d_if.narrow_req_we_i = '0; d_if.narrow_req_wdata_i = '0;
    d_if.narrow_req_strb_i = '0; d_if.wide_req_addr_i = '0; d_if.wide_req_we_i = 1'b0;
    d_if.wide_req_wdata_i = '0; d_if.wide_req_strb_i = '0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_all();
    clear_fields();
    do_reset();

    @(negedge clk);
    chk("rst_a_wstarved", a_if.wide_starved_o, 1'b0);
    chk("rst_a_nstarved", a_if.narrow_starved_o, 1'b0);
    chk("rst_a_wrsp", a_if.wide_rsp_valid_o, 1'b0);
    chk("rst_a_nrsp", a_if.narrow_rsp_valid_o, 4'b0000);
    chk("rst_c_nrsp", c_if.narrow_rsp_valid_o, 4'b0000);
    next_cycle();

    // Narrow-first, MaxStall 3: wide forced through on cycle 3
    do_reset();
    for (int c = 0; c < 6; c++) begin
      a_if.narrow_req_valid_i = 4'b0001;
      a_if.wide_req_valid_i   = (c <= 3);
      @(negedge clk);
      chk($sformatf("nf_wready c%0d", c), a_if.wide_req_ready_o, (c == 3));
      chk($sformatf("nf_nready c%0d", c), a_if.narrow_req_ready_o, (c == 3) ? 4'b0000 : 4'b0001);
      chk($sformatf("nf_bankreq c%0d", c), a_if.bank_req_o, (c == 3) ? 4'b1111 : 4'b0001);
      chk($sformatf("nf_wstarved c%0d", c), a_if.wide_starved_o, (c == 3));
      chk($sformatf("nf_wrsp c%0d", c), a_if.wide_rsp_valid_o, (c == 4));
      chk($sformatf("nf_nrsp c%0d", c), a_if.narrow_rsp_valid_o,
          (c >= 1 && c != 4) ? 4'b0001 : 4'b0000);
      if (c == 4) chk("nf_wrdata", a_if.wide_rsp_rdata_o, RD);
      next_cycle();
    end

    // Wide-first, MaxStall 2: narrow read on bank 2 gets every third cycle
    do_reset();
    for (int c = 0; c < 9; c++) begin
      b_if.wide_req_valid_i   = 1'b1;
      b_if.wide_req_we_i      = 1'b1;
      b_if.wide_req_strb_i    = '1;
      b_if.narrow_req_valid_i = 4'b0100;
      @(negedge clk);
      chk($sformatf("wf_nready c%0d", c), b_if.narrow_req_ready_o, (c % 3 == 2) ? 4'b0100 : 4'b0000);
      chk($sformatf("wf_wready c%0d", c), b_if.wide_req_ready_o, (c % 3 != 2));
      chk($sformatf("wf_nstarved c%0d", c), b_if.narrow_starved_o, (c % 3 == 2));
      chk($sformatf("wf_bankwe c%0d", c), b_if.bank_we_o, (c % 3 == 2) ? 4'b0000 : 4'b1111);
      chk($sformatf("wf_nrsp c%0d", c), b_if.narrow_rsp_valid_o,
          (c >= 1 && (c - 1) % 3 == 2) ? 4'b0100 : 4'b0000);
      chk($sformatf("wf_wrsp c%0d", c), b_if.wide_rsp_valid_o, (c >= 1 && (c - 1) % 3 != 2));
      if (c >= 1 && (c - 1) % 3 == 2)
        chk($sformatf("wf_nrdata c%0d", c), b_if.narrow_rsp_rdata_o[95:64], 32'h3333_0003);
      next_cycle();
    end

    // Round robin: narrow, wide, narrow, wide ... from reset
    do_reset();
    for (int c = 0; c < 6; c++) begin
      c_if.narrow_req_valid_i = 4'b0011;
      c_if.wide_req_valid_i   = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_wready c%0d", c), c_if.wide_req_ready_o, (c % 2 == 1));
      chk($sformatf("rr_nready c%0d", c), c_if.narrow_req_ready_o, (c % 2 == 0) ? 4'b0011 : 4'b0000);
      chk($sformatf("rr_wrsp c%0d", c), c_if.wide_rsp_valid_o, (c >= 3 && c % 2 == 1));
      chk($sformatf("rr_nrsp c%0d", c), c_if.narrow_rsp_valid_o,
          (c >= 2 && c % 2 == 0) ? 4'b0011 : 4'b0000);
      next_cycle();
    end

    // Latency 3: wide write then wide read of row 5
    do_reset();
    for (int c = 0; c < 6; c++) begin
      d_if.wide_req_valid_i = (c <= 1);
      d_if.wide_req_we_i    = (c == 0);
      d_if.wide_req_addr_i  = 16'h0005;
      d_if.wide_req_wdata_i = WIDE_PAT;
      d_if.wide_req_strb_i  = '1;
      @(negedge clk);
      chk($sformatf("l3_wready c%0d", c), d_if.wide_req_ready_o, (c <= 1));
      if (c == 0) chk("l3_bankaddr", d_if.bank_addr_o, 64'h0005_0005_0005_0005);
      chk($sformatf("l3_wrsp c%0d", c), d_if.wide_rsp_valid_o, (c == 3 || c == 4));
      if (c == 4) chk("l3_rdata", d_if.wide_rsp_rdata_o, WIDE_PAT);
      next_cycle();
    end

    // Narrow-only on banks 0 and 3
    do_reset();
    for (int c = 0; c < 3; c++) begin
      a_if.narrow_req_valid_i = (c == 0) ? 4'b1001 : 4'b0000;
      a_if.narrow_req_addr_i  = 64'h0D03_0000_0000_0A00;
      @(negedge clk);
      chk($sformatf("no_nready c%0d", c), a_if.narrow_req_ready_o, (c == 0) ? 4'b1001 : 4'b0000);
      chk($sformatf("no_bankreq c%0d", c), a_if.bank_req_o, (c == 0) ? 4'b1001 : 4'b0000);
      chk($sformatf("no_wready c%0d", c), a_if.wide_req_ready_o, 1'b0);
      chk($sformatf("no_nrsp c%0d", c), a_if.narrow_rsp_valid_o, (c == 1) ? 4'b1001 : 4'b0000);
      if (c == 0) chk("no_bankaddr", a_if.bank_addr_o, 64'h0D03_0000_0000_0A00);
      if (c == 1) chk("no_nrdata", a_if.narrow_rsp_rdata_o, RD);
      next_cycle();
    end

    // One-cycle reset with two narrow grants in flight (latency 2)
    do_reset();
    for (int c = 0; c < 7; c++) begin
      c_if.narrow_req_valid_i = (c <= 1 || c >= 5) ? 4'b0011 : 4'b0000;
      c_if.wide_req_valid_i   = (c == 0 || c >= 5);
      rst_n = (c != 2);
      @(negedge clk);
      if (c <= 1) chk($sformatf("mr_nready c%0d", c), c_if.narrow_req_ready_o, 4'b0011);
      if (c >= 2 && c <= 4)
        chk($sformatf("mr_nrsp c%0d", c), c_if.narrow_rsp_valid_o, (c == 2) ? 4'b0011 : 4'b0000);
      if (c >= 3 && c <= 4) chk($sformatf("mr_wrsp c%0d", c), c_if.wide_rsp_valid_o, 1'b0);
      if (c >= 5) begin
        chk($sformatf("mr_wready c%0d", c), c_if.wide_req_ready_o, (c == 6));
        chk($sformatf("mr_wstarved c%0d", c), c_if.wide_starved_o, 1'b0);
      end
      next_cycle();
    end
    idle_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
